// File: rtl/dco_trim_calibrator.sv
// Closed-loop trim controller for the 13-stage ring oscillator: counts clk cycles per
// reference period and steps a 0..25 thermometer-encoded trim code toward div.
module dco_trim_calibrator #(
    parameter int CNT_W     = 7,
    parameter int TOL       = 1,
    parameter int LOCK_N    = 4,
    parameter int INIT_CODE = 12
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             enable,
    input  logic             hold,
    input  logic             osc,
    input  logic [CNT_W-1:0] div,
    output logic [25:0]      trim,
    output logic [4:0]       code,
    output logic             locked,
    output logic             ref_lost
);

    typedef enum logic [2:0] {IDLE, ARM, MEASURE, EVAL, SETTLE} state_t;

    localparam int LOCK_W = $clog2(LOCK_N + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]    MEAS_ONE  = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]    TOL_W     = (CNT_W + 1)'(TOL);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_N);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
    localparam logic [4:0]        CODE_MAX  = 5'd25;
    localparam logic [4:0]        CODE_INIT = 5'(INIT_CODE);

    // Primary-first thermometer: the low 13 stages fill before the secondary 13.
    function automatic logic [25:0] encode(input logic [4:0] n);
        logic [25:0] t;
        t = '0;
        for (int i = 0; i < 13; i++) begin
            t[i]      = (int'(n) > i);
            t[13 + i] = (int'(n) > 13 + i);
        end
        return t;
    endfunction

    logic rst_meta;
    logic rst_n;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    logic osc_s1, osc_s2, osc_s3;
    logic ref_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_s1 <= 1'b0;
            osc_s2 <= 1'b0;
            osc_s3 <= 1'b0;
        end else begin
            osc_s1 <= osc;
            osc_s2 <= osc_s1;
            osc_s3 <= osc_s2;
        end
    end

    assign ref_edge = osc_s2 & ~osc_s3;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [CNT_W:0]     meas, meas_nxt;
    logic [LOCK_W-1:0]  lock_cnt, lock_cnt_nxt;
    logic [4:0]         code_nxt;
    logic               locked_nxt;
    logic               ref_lost_nxt;

    logic               count_sat;
    logic [CNT_W-1:0]   count_inc;
    logic [CNT_W:0]     div_w;
    logic               too_fast;
    logic               too_slow;

    assign count_sat = (count == CNT_MAX);
    assign count_inc = count_sat ? count : count + CNT_ONE;
    assign div_w     = {1'b0, div};
    assign too_fast  = (meas > div_w + TOL_W);
    assign too_slow  = (meas + TOL_W < div_w);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            meas     <= '0;
            lock_cnt <= '0;
            code     <= CODE_INIT;
            locked   <= 1'b0;
            ref_lost <= 1'b0;
            trim     <= encode(CODE_INIT);
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            meas     <= meas_nxt;
            lock_cnt <= lock_cnt_nxt;
            code     <= code_nxt;
            locked   <= locked_nxt;
            ref_lost <= ref_lost_nxt;
            trim     <= encode(code);
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        meas_nxt     = meas;
        lock_cnt_nxt = lock_cnt;
        code_nxt     = code;
        locked_nxt   = locked;
        ref_lost_nxt = ref_lost;

        if (!enable) begin
            state_nxt    = IDLE;
            count_nxt    = '0;
            lock_cnt_nxt = '0;
            code_nxt     = CODE_INIT;
            locked_nxt   = 1'b0;
            ref_lost_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count_nxt = '0;
                    state_nxt = ARM;
                end
                ARM: begin
                    count_nxt = count_inc;
                    if (ref_edge) begin
                        count_nxt = '0;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    // A period that saturated the counter is meaningless; re-arm instead.
                    if (ref_edge) begin
                        count_nxt = '0;
                        if (ref_lost) begin
                            ref_lost_nxt = 1'b0;
                            state_nxt    = ARM;
                        end else begin
                            meas_nxt  = {1'b0, count} + MEAS_ONE;
                            state_nxt = EVAL;
                        end
                    end else if (count_sat) begin
                        ref_lost_nxt = 1'b1;
                    end else begin
                        count_nxt = count + CNT_ONE;
                    end
                end
                EVAL: begin
                    count_nxt = count_inc;
                    state_nxt = MEASURE;
                    if (too_fast || too_slow) begin
                        lock_cnt_nxt = '0;
                        locked_nxt   = 1'b0;
                        if (!hold) begin
                            if (too_fast && code != CODE_MAX) begin
                                code_nxt  = code + 5'd1;
                                state_nxt = SETTLE;
                            end else if (too_slow && code != 5'd0) begin
                                code_nxt  = code - 5'd1;
                                state_nxt = SETTLE;
                            end
                        end
                    end else begin
                        if (lock_cnt != LOCK_MAX) begin
                            lock_cnt_nxt = lock_cnt + LOCK_ONE;
                        end
                        if (lock_cnt_nxt == LOCK_MAX) begin
                            locked_nxt = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    count_nxt = count_inc;
                    if (ref_edge) begin
                        count_nxt = '0;
                        state_nxt = MEASURE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dco_trim_calibrator.sv
// Self-checking bench: a reference-period plant model plus a period-level controller
// model feeding a scoreboard that is compared a fixed latency after each osc edge.
module tb_dco_trim_calibrator;

    localparam int CNT_W  = 7;
    localparam int S_ARM  = 0;
    localparam int S_MEAS = 1;
    localparam int S_SETL = 2;

    logic             clk;
    logic             resetb;
    logic             enable;
    logic             hold;
    logic             osc;
    logic [CNT_W-1:0] div;
    logic [25:0]      trim;
    logic [4:0]       code;
    logic             locked;
    logic             ref_lost;

    dco_trim_calibrator #(
        .CNT_W(CNT_W), .TOL(1), .LOCK_N(4), .INIT_CODE(12)
    ) dut (
        .clk(clk), .resetb(resetb), .enable(enable), .hold(hold), .osc(osc),
        .div(div), .trim(trim), .code(code), .locked(locked), .ref_lost(ref_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  code;
        logic        locked;
        logic        ref_lost;
        logic [25:0] trim;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    int mcode, mlock_cnt, mstate, last_p, plant_mode;
    logic mlocked, mref_lost;
    logic reset_armed, reset_done;

    function automatic logic [25:0] model_trim(input int n);
        logic [25:0] t;
        t = '0;
        for (int i = 0; i < 13; i++) if (i < n) t[i] = 1'b1;
        for (int i = 0; i < 13; i++) if (i < n - 13) t[13 + i] = 1'b1;
        return t;
    endfunction

    function automatic int plant_period(input int c);
        if (plant_mode == 0) return 30 - c;
        if (plant_mode == 1) return 60;
        return 30;
    endfunction

    task automatic model_reset();
        mcode     = 12;
        mlock_cnt = 0;
        mlocked   = 1'b0;
        mref_lost = 1'b0;
        mstate    = S_ARM;
    endtask

    // Advance the controller model by one reference edge and queue its visible outputs.
    task automatic model_rise();
        exp_t e;
        int   m, nc, d;
        m = last_p;
        d = int'(div);
        if (mstate == S_ARM || mstate == S_SETL) begin
            mstate = S_MEAS;
        end else if (mref_lost) begin
            mref_lost = 1'b0;
            mstate    = S_ARM;
        end else if (m > d + 1 || m + 1 < d) begin
            mlock_cnt = 0;
            mlocked   = 1'b0;
            nc        = mcode;
            if (!hold) nc = (m > d + 1) ? ((mcode < 25) ? mcode + 1 : 25)
                                        : ((mcode > 0) ? mcode - 1 : 0);
            mstate = (nc != mcode) ? S_SETL : S_MEAS;
            mcode  = nc;
        end else begin
            if (mlock_cnt < 4) mlock_cnt++;
            if (mlock_cnt == 4) mlocked = 1'b1;
            mstate = S_MEAS;
        end
        e.code     = 5'(mcode);
        e.locked   = mlocked;
        e.ref_lost = mref_lost;
        e.trim     = model_trim(mcode);
        sb.push_back(e);
    endtask

    // One reference period of p clk cycles, starting with a rising osc edge.
    task automatic osc_period(input int p);
        exp_t e;
        int   hi;
        hi = p / 2;
        model_rise();
        osc = 1'b1;
        for (int i = 1; i <= p; i++) begin
            @(posedge clk); #1;
            if (i == hi) osc = 1'b0;
            if (i == 5) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("[TB] FAIL scoreboard_empty: got 0 entries required 1");
                end else begin
                    e = sb.pop_front();
                    vectors++;
                    if (code !== e.code) begin
                        miscompares++;
                        $display("[TB] FAIL sb_code: got %0d required %0d", code, e.code);
                    end
                    vectors++;
                    if (locked !== e.locked) begin
                        miscompares++;
                        $display("[TB] FAIL sb_locked: got %0b required %0b", locked, e.locked);
                    end
                    vectors++;
                    if (ref_lost !== e.ref_lost) begin
                        miscompares++;
                        $display("[TB] FAIL sb_ref_lost: got %0b required %0b", ref_lost, e.ref_lost);
                    end
                    vectors++;
                    if (trim !== e.trim) begin
                        miscompares++;
                        $display("[TB] FAIL sb_trim: got %07h required %07h", trim, e.trim);
                    end
                end
            end
            if (p > 140 && i == 150) begin
                if (mstate == S_MEAS) mref_lost = 1'b1;
                vectors++;
                if (ref_lost !== mref_lost) begin
                    miscompares++;
                    $display("[TB] FAIL gap_ref_lost: got %0b required %0b", ref_lost, mref_lost);
                end
                vectors++;
                if (code !== 5'(mcode)) begin
                    miscompares++;
                    $display("[TB] FAIL gap_code_frozen: got %0d required %0d", code, mcode);
                end
            end
            if (reset_armed && !reset_done && i == 20 && mcode == 20 && mstate == S_MEAS) begin
                resetb = 1'b0;
                #1;
                vectors++;
                if (code !== 5'd12) begin
                    miscompares++;
                    $display("[TB] FAIL midrun_reset_code: got %0d required 12", code);
                end
                vectors++;
                if (locked !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL midrun_reset_locked: got %0b required 0", locked);
                end
                vectors++;
                if (trim !== 26'h0000FFF) begin
                    miscompares++;
                    $display("[TB] FAIL midrun_reset_trim: got %07h required 0000fff", trim);
                end
                enable = 1'b0;
                model_reset();
                reset_done = 1'b1;
            end
        end
        last_p = p;
    endtask

    task automatic enable_on();
        model_reset();
        enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetb = 1'b0; enable = 1'b0; hold = 1'b0; osc = 1'b0; div = 7'd20;
        plant_mode = 0; last_p = 0; reset_armed = 1'b0; reset_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (code !== 5'd12) begin miscompares++; $display("[TB] FAIL rst_code: got %0d required 12", code); end
        vectors++;
        if (trim !== 26'h0000FFF) begin miscompares++; $display("[TB] FAIL rst_trim: got %07h required 0000fff", trim); end
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_locked: got %0b required 0", locked); end
        vectors++;
        if (ref_lost !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ref_lost: got %0b required 0", ref_lost); end
        resetb = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (code !== 5'd12) begin miscompares++; $display("[TB] FAIL idle_code: got %0d required 12", code); end
        vectors++;
        if (trim !== 26'h0000FFF) begin miscompares++; $display("[TB] FAIL idle_trim: got %07h required 0000fff", trim); end
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_locked: got %0b required 0", locked); end
    endtask

    task automatic test_converge();
        plant_mode = 0;
        div = 7'd20;
        enable_on();
        for (int k = 0; k < 10; k++) osc_period(plant_period(mcode));
        vectors++;
        if (code !== 5'd11) begin miscompares++; $display("[TB] FAIL conv_code: got %0d required 11", code); end
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("[TB] FAIL conv_locked: got %0b required 1", locked); end
    endtask

    task automatic test_ref_lost();
        osc_period(200);
        for (int k = 0; k < 3; k++) osc_period(plant_period(mcode));
        vectors++;
        if (ref_lost !== 1'b0) begin miscompares++; $display("[TB] FAIL relock_ref_lost: got %0b required 0", ref_lost); end
        vectors++;
        if (code !== 5'd11) begin miscompares++; $display("[TB] FAIL relock_code: got %0d required 11", code); end
    endtask

    task automatic test_hold();
        hold = 1'b1;
        plant_mode = 2;
        for (int k = 0; k < 3; k++) osc_period(plant_period(mcode));
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_locked: got %0b required 0", locked); end
        vectors++;
        if (code !== 5'd11) begin miscompares++; $display("[TB] FAIL hold_code: got %0d required 11", code); end
        hold = 1'b0;
        for (int k = 0; k < 4; k++) osc_period(plant_period(mcode));
        vectors++;
        if (code !== 5'd13) begin miscompares++; $display("[TB] FAIL unhold_code: got %0d required 13", code); end
    endtask

    task automatic test_rail();
        enable = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (code !== 5'd12) begin miscompares++; $display("[TB] FAIL disable_code: got %0d required 12", code); end
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL disable_locked: got %0b required 0", locked); end
        @(posedge clk); #1;
        vectors++;
        if (trim !== 26'h0000FFF) begin miscompares++; $display("[TB] FAIL disable_trim: got %07h required 0000fff", trim); end
        plant_mode = 1;
        enable_on();
        for (int k = 0; k < 32; k++) osc_period(plant_period(mcode));
        vectors++;
        if (code !== 5'd25) begin miscompares++; $display("[TB] FAIL rail_code: got %0d required 25", code); end
        vectors++;
        if (trim !== 26'h1FFFFFF) begin miscompares++; $display("[TB] FAIL rail_trim: got %07h required 1ffffff", trim); end
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL rail_locked: got %0b required 0", locked); end
    endtask

    task automatic test_reset_midrun();
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        plant_mode  = 1;
        enable_on();
        reset_armed = 1'b1;
        for (int k = 0; k < 40 && !reset_done; k++) osc_period(plant_period(mcode));
        if (!reset_done) begin
            vectors++; miscompares++;
            $display("[TB] FAIL midrun_reach_code20: got %0d required 20", code);
        end
        resetb = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (code !== 5'd12) begin miscompares++; $display("[TB] FAIL post_reset_code: got %0d required 12", code); end
        vectors++;
        if (trim !== 26'h0000FFF) begin miscompares++; $display("[TB] FAIL post_reset_trim: got %07h required 0000fff", trim); end
    endtask

    initial begin
        test_reset();
        test_converge();
        test_ref_lost();
        test_hold();
        test_rail();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
